// File: rtl/pri_enc_pkg.sv
// Shared constants, FSM encoding and decode helper for the priority
// encoder/decoder path.
package pri_enc_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 1 << CODE_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } state_e;

  function automatic logic [OUT_W-1:0] onehot_of(input logic none,
                                                 input logic [CODE_W-1:0] code);
    onehot_of = none ? '0 : (OUT_W'(1) << code);
  endfunction

endpackage

// File: rtl/pri_dec_2_4_seq_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB compare.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; clearing the pointers is enough to drop contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pri_dec_2_4_seq.sv
// Buffers {none, code} words and replays each as a registered one-hot grant
// on a valid/ack stream, counting acknowledged words.
module pri_dec_2_4_seq
  import pri_enc_pkg::*;
#(
  parameter int CODE_W = pri_enc_pkg::CODE_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int OUT_W = 1 << CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_none,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_none,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [CNT_W-1:0]  out_count
);

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  onehot_q, onehot_d;
  logic              none_q, none_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CODE_W:0]   fifo_dout;
  logic [CODE_W-1:0] head_code;
  logic              head_none;

  sync_fifo #(.WIDTH(CODE_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   ({in_none, in_code}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign head_none = fifo_dout[CODE_W];
  assign head_code = fifo_dout[CODE_W-1:0];

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    none_d   = none_q;
    valid_d  = valid_q;
    count_d  = count_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          onehot_d = onehot_of(head_none, head_code);
          none_d   = head_none;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (out_ack) begin
          count_d = count_q + CNT_W'(1);
          // Refill straight from the FIFO so acked words stream with no bubble.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            onehot_d = onehot_of(head_none, head_code);
            none_d   = head_none;
          end else begin
            onehot_d = '0;
            none_d   = 1'b0;
            valid_d  = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      onehot_q <= '0;
      none_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      none_q   <= none_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_none   = none_q;
  assign out_valid  = valid_q;
  assign out_count  = count_q;

endmodule
